// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the types handed to the downstream renderer.
// Defaults give 640x480@60 Hz from a 100 MHz clock with a divide-by-4 pixel rate.
package vga_pkg;

  localparam int CLK_DIV  = 4;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam bit H_POL    = 1'b0;
  localparam bit V_POL    = 1'b0;

  localparam int CNT_W    = 10;

  typedef logic [CNT_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   active;
    logic   hsync;
    logic   vsync;
    logic   line_start;
    logic   frame_start;
  } vga_timing_t;

endpackage

// File: rtl/vga_timing_gen_pix_tick_gen.sv
// Pixel-rate strobe: divides clk by CLK_DIV and registers a one-clk pix_tick.
// tick_next is the strobe's next value, letting the raster counters move on the same edge.
module pix_tick_gen #(
  parameter int CLK_DIV = vga_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pix_tick,
  output logic tick_next
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_tick_q, pix_tick_d;

  always_comb begin
    div_d      = div_q;
    pix_tick_d = 1'b0;
    if (en) begin
      if (div_q == DIV_LAST) begin
        div_d      = '0;
        pix_tick_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pix_tick_q <= pix_tick_d;
    end
  end

  assign pix_tick  = pix_tick_q;
  assign tick_next = pix_tick_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: counters, active-video window, syncs and line/frame pulses.
// Every output is registered from the next counter values, so all change on one edge.
module vga_timing_gen #(
  parameter int CLK_DIV  = vga_pkg::CLK_DIV,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter bit H_POL    = vga_pkg::H_POL,
  parameter bit V_POL    = vga_pkg::V_POL,
  parameter int CNT_W    = vga_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             pix_tick,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             Hsync,
  output logic             Vsync,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((CLK_DIV < 2) || (H_TOTAL >= (1 << CNT_W)) || (V_TOTAL >= (1 << CNT_W))) begin : g_bad_params
    $fatal(1, "vga_timing_gen: CLK_DIV must be >= 2 and raster totals must fit in CNT_W bits");
  end

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT_C  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_C  = cnt_t'(V_ACTIVE);
  localparam cnt_t H_SS     = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_SE     = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t V_SS     = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t V_SE     = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  logic tick_next;

  cnt_t hcnt_q, hcnt_d;
  cnt_t vcnt_q, vcnt_d;
  cnt_t x_q, x_d;
  cnt_t y_q, y_d;
  logic active_q, active_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pix_tick  (pix_tick),
    .tick_next (tick_next)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    x_d           = x_q;
    y_d           = y_q;
    active_d      = active_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (!en) begin
      // Disabled: blank video, freeze position, keep sync levels steady for the monitor.
      active_d = 1'b0;
      x_d      = '0;
      y_d      = '0;
    end else if (tick_next) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end

      active_d      = (hcnt_d < H_ACT_C) && (vcnt_d < V_ACT_C);
      x_d           = active_d ? hcnt_d : '0;
      y_d           = active_d ? vcnt_d : '0;
      hsync_d       = ((hcnt_d >= H_SS) && (hcnt_d < H_SE)) ? H_POL : ~H_POL;
      vsync_d       = ((vcnt_d >= V_SS) && (vcnt_d < V_SE)) ? V_POL : ~V_POL;
      line_start_d  = (hcnt_d == '0);
      frame_start_d = (hcnt_d == '0) && (vcnt_d == '0);
    end
  end

  // Reset parks on the last raster position so the first tick lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q        <= H_LAST;
      vcnt_q        <= V_LAST;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock for the basys3_vga top level. Supplies the pixel-rate strobe, raster counters, pixel coordinates, active-video flag, and Hsync/Vsync, plus line/frame start pulses. It sits directly upstream of the sprite/table renderer and the colour output registers driving vgaRed/vgaGreen/vgaBlue.

Parameters:
CLK_DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz pixel rate); must be >= 2
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, asserted level of Hsync
V_POL, 0, asserted level of Vsync
CNT_W, 10, counter/coordinate width

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low freezes timing and blanks video
pix_tick  out  1  one-clk strobe, once per pixel period
hcnt  out  CNT_W  horizontal raster counter, 0..H_TOTAL-1
vcnt  out  CNT_W  vertical raster counter, 0..V_TOTAL-1
x  out  CNT_W  pixel column while active, else 0
y  out  CNT_W  pixel row while active, else 0
active  out  1  high inside the visible region
Hsync  out  1  horizontal sync
Vsync  out  1  vertical sync
line_start  out  1  one-clk pulse when hcnt becomes 0
frame_start  out  1  one-clk pulse when (hcnt,vcnt) becomes (0,0)

Behaviour:
- Timing totals: H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525). Frame period = 800*525*4 = 1,680,000 clk.
- Clock and reset: one clock domain. rst_n is asynchronous and active-low. Every register clears immediately on rst_n low, without waiting for a clk edge.
- Reset values: div=0, hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, pix_tick=0, active=0, x=0, y=0, line_start=0, frame_start=0, Hsync=~H_POL, Vsync=~V_POL.
- Divider: div counts 0..CLK_DIV-1 while en=1. pix_tick is registered and is 1 for exactly the clk cycle after div==CLK_DIV-1.
- Counter advance: on each pix_tick event, hcnt increments. At H_TOTAL-1, hcnt wraps to 0 and vcnt increments. At V_TOTAL-1, vcnt wraps to 0.
- Output registration: all outputs are registered and computed from the next counter values. They therefore change on the same edge as hcnt/vcnt, with zero relative skew.
- active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE). While active, x=hcnt and y=vcnt; otherwise both are 0.
- Hsync = H_POL when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise ~H_POL.
- Vsync = V_POL when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (490..491); otherwise ~V_POL.
- line_start: 1 for the single clk in which hcnt has just become 0.
- frame_start: 1 for the single clk in which hcnt and vcnt have just both become 0. It always coincides with a line_start pulse.
- First frame after reset: reset preloads the last raster position, so the first pix_tick produces (0,0) with active=1, line_start=1 and frame_start=1.
- en=0: div, hcnt and vcnt hold. pix_tick, line_start and frame_start are 0. active is forced to 0 and x,y to 0. Hsync and Vsync hold their current levels.
- en returning to 1: div resumes from its held value. The next tick advances hcnt by exactly 1, and active is recomputed on that tick.
- Simultaneous wraps: horizontal and vertical wraps on the same tick are handled in one update, with no extra cycle.
- Widths: counter arithmetic is unsigned CNT_W bits. Parameter totals must fit in CNT_W; an elaboration-time assertion enforces this.

Decomposition:
- Package vga_pkg holds:
  - default timing constants H_*/V_* and derived H_TOTAL/V_TOTAL;
  - CNT_W;
  - typedef coord_t (logic [CNT_W-1:0]);
  - struct vga_timing_t bundling x, y, active, Hsync, Vsync, line_start and frame_start, for consumption by the renderer.
- One natural sub-module: pix_tick_gen. It contains the CLK_DIV counter and registered strobe, with clk, rst_n and en inputs and a pix_tick output.

Test Plan:
1. Reset released, en=1 -> first pix_tick at the 4th clk. On that tick hcnt=0, vcnt=0, active=1, line_start=1, frame_start=1; both pulses are exactly one clk wide.
2. Run one line -> Hsync=0 from hcnt=656 through 751 (384 clk); line_start period = 3200 clk; active falls when hcnt=640.
3. Run one frame -> Vsync=0 for vcnt 490..491 (6400 clk); frame_start period = 1,680,000 clk; x max 639, y max 479; active ticks per frame = 307,200.
4. Drop en at hcnt=100 for 50 clk, then raise it -> counters hold at 100, active=0 and no pix_tick while en=0; after re-enable the next tick gives hcnt=101.
5. Pulse rst_n low mid-frame between clk edges -> outputs take their reset values asynchronously (Hsync=1, Vsync=1, active=0); after release the sequence restarts exactly as in scenario 1.
6. Override CLK_DIV=2 with small H/V parameters -> wraps, sync windows and the coincident frame_start/line_start pulse all track the parameters.
